memarb: RTL and testbench

Two-port arbiter that shares one single-port, synchronous-read memory between the instruction-fetch path (IF stage, read-only) and the data path (MA/MO stages, read/write). It allows a unified program/data store to replace the split instruction and data memories. It issues at most one memory access per cycle and gives data accesses priority, with a starvation guard for fetch. It routes the one-cycle-late read data back to the requester that issued the read, and drops fetch responses squashed by a branch flush.

---
 rtl/diad_pkg.sv | 14 +
 rtl/memarb_starve.sv | 31 +++
 rtl/memarb.sv | 104 ++++++++++
 tb/tb_memarb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/diad_pkg.sv
// Definitions shared across the diad pipeline stages: bus widths and the
// memory response tag used by the memory arbiter.
package diad_pkg;

  localparam int unsigned DIAD_ADDR_W = 24;
  localparam int unsigned DIAD_DATA_W = 24;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_t;

endpackage

// File: rtl/memarb_starve.sv
// Fetch starvation guard: counts contended cycles lost by fetch and forces a
// fetch win once the count reaches STARVE_LIMIT.
module memarb_starve #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic contended,
  input  logic i_granted,
  output logic force_i
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  // A contended cycle without a fetch grant is a cycle data won.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (i_granted) begin
      starve_cnt <= '0;
    end else if (contended && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign force_i = (starve_cnt == LIMIT);

endmodule

// File: rtl/memarb.sv
// Shares one synchronous-read single-port memory between instruction fetch and
// the data path; data has priority, fetch is protected by a starvation guard.
module memarb
  import diad_pkg::*;
#(
  parameter int unsigned ADDR_W       = DIAD_ADDR_W,
  parameter int unsigned DATA_W       = DIAD_DATA_W,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic  i_eff;
  logic  contended;
  logic  force_i;
  resp_t resp_q;

  assign i_eff     = i_req && !i_flush;
  assign contended = i_eff && d_req;

  memarb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .contended (contended),
    .i_granted (i_gnt),
    .force_i   (force_i)
  );

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (contended) begin
        i_gnt = force_i;
        d_gnt = !force_i;
      end else begin
        i_gnt = i_eff;
        d_gnt = d_req;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= RESP_NONE;
    end else if (i_gnt) begin
      resp_q <= RESP_I;
    end else if (d_gnt && !d_we) begin
      resp_q <= RESP_D;
    end else begin
      resp_q <= RESP_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (contended && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // Gating with rst drops a response already in flight when reset hits.
  assign i_rvalid = (resp_q == RESP_I) && !i_flush && !rst;
  assign d_rvalid = (resp_q == RESP_D) && !rst;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_memarb.sv
// Self-checking bench for memarb: table-driven vectors with a response
// scoreboard, plus contention, reset and counter-saturation sequences.
module tb_memarb;

  typedef struct {
    logic        rst;
    logic        i_req;
    logic [23:0] i_addr;
    logic        i_flush;
    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [23:0] d_wdata;
    logic        eg_i;
    logic        eg_d;
  } vec_t;

  typedef struct {
    logic        is_i;
    logic [23:0] data;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, d_req, d_we;
  logic [23:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we;
  logic [23:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;
  logic        i_gnt4, i_rvalid4, d_gnt4, d_rvalid4, mem_we4;
  logic [23:0] i_rdata4, d_rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  conflict_cnt4;

  logic [23:0] mem    [0:4095];
  logic [23:0] shadow [0:4095];

  int checks = 0;
  int errors = 0;
  int conf_m = 0;
  int conf4_m = 0;
  resp_exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  memarb dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  memarb #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt4),
    .i_rvalid(i_rvalid4), .i_rdata(i_rdata4),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt4),
    .d_rvalid(d_rvalid4), .d_rdata(d_rdata4),
    .mem_addr(mem_addr4), .mem_we(mem_we4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt4)
  );

  // Synchronous-read memory; a write is visible to a read issued next cycle.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:0]];
  end

  function automatic logic [23:0] init_val(int k);
    return 24'(32'(k) * 32'h111) ^ 24'hA50000;
  endfunction

  function automatic vec_t mk(logic r, logic ir, logic [23:0] ia, logic fl, logic dr,
                              logic we, logic [23:0] da, logic [23:0] wd,
                              logic egi, logic egd);
    vec_t v;
    v.rst = r; v.i_req = ir; v.i_addr = ia; v.i_flush = fl; v.d_req = dr;
    v.d_we = we; v.d_addr = da; v.d_wdata = wd; v.eg_i = egi; v.eg_d = egd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v);
    resp_exp_t r;
    logic exp_iv, exp_dv;
    logic [23:0] exp_data, exp_addr, exp_wdata;
    logic exp_we;
    rst = v.rst; i_req = v.i_req; i_addr = v.i_addr; i_flush = v.i_flush;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    #1;
    exp_iv = 1'b0; exp_dv = 1'b0; exp_data = '0;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      exp_data = r.data;
      if (r.is_i) exp_iv = !v.i_flush && !v.rst;
      else        exp_dv = !v.rst;
    end
    chk("i_rvalid", 32'(i_rvalid), 32'(exp_iv));
    chk("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
    if (exp_iv) chk("i_rdata", 32'(i_rdata), 32'(exp_data));
    if (exp_dv) chk("d_rdata", 32'(d_rdata), 32'(exp_data));
    chk("i_gnt", 32'(i_gnt), 32'(v.eg_i));
    chk("d_gnt", 32'(d_gnt), 32'(v.eg_d));
    exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
    if (v.eg_d) begin
      exp_addr = v.d_addr; exp_we = v.d_we; exp_wdata = v.d_wdata;
    end else if (v.eg_i) begin
      exp_addr = v.i_addr;
    end
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(conf_m));
    chk("conflict_cnt4", 32'(conflict_cnt4), 32'(conf4_m));
    if (v.eg_i) begin
      r.is_i = 1'b1; r.data = shadow[v.i_addr[11:0]]; sb.push_back(r);
    end
    if (v.eg_d && !v.d_we) begin
      r.is_i = 1'b0; r.data = shadow[v.d_addr[11:0]]; sb.push_back(r);
    end
    if (v.eg_d && v.d_we) shadow[v.d_addr[11:0]] = v.d_wdata;
    if (v.rst) begin
      conf_m = 0; conf4_m = 0;
    end else if (v.i_req && !v.i_flush && v.d_req) begin
      if (conf_m < 16'hFFFF) conf_m++;
      if (conf4_m < 15) conf4_m++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) begin
      mem[k] = init_val(k);
      shadow[k] = init_val(k);
    end
    rst = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 0, 24'h0,   24'h0,    0, 0));
    for (int a = 'h10; a <= 'h13; a++)
      tbl.push_back(mk(0, 1, 24'(a), 0, 0, 0, 24'h0,  24'h0,    1, 0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 0, 24'h0,   24'h0,    0, 0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 1, 24'h100, 24'hABCD, 0, 1));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 0, 24'h100, 24'h0,    0, 1));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 0, 24'h0,   24'h0,    0, 0));
    tbl.push_back(mk(0, 1, 24'h20,  0, 0, 0, 24'h0,   24'h0,    1, 0));
    tbl.push_back(mk(0, 1, 24'h21,  1, 1, 0, 24'h30,  24'h0,    0, 1));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 0, 24'h0,   24'h0,    0, 0));
    tbl.push_back(mk(0, 1, 24'h22,  1, 0, 0, 24'h0,   24'h0,    0, 0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 0, 24'h40,  24'h0,    0, 1));
    tbl.push_back(mk(0, 1, 24'h41,  0, 0, 0, 24'h0,   24'h0,    1, 0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 1, 24'h41,  24'h123,  0, 1));
    tbl.push_back(mk(0, 1, 24'h41,  0, 0, 0, 24'h0,   24'h0,    1, 0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 0, 24'h0,   24'h0,    0, 0));
    foreach (tbl[n]) apply(tbl[n]);

    // Contention after a mid-flight reset: starve count must restart at zero.
    apply(mk(1, 0, 24'h0, 0, 0, 0, 24'h0, 24'h0, 0, 0));
    apply(mk(0, 1, 24'h50, 0, 1, 0, 24'h200, 24'h0, 0, 1));
    apply(mk(0, 1, 24'h50, 0, 1, 0, 24'h201, 24'h0, 0, 1));
    apply(mk(1, 0, 24'h0,  0, 0, 0, 24'h0,   24'h0, 0, 0));
    for (int k = 0; k < 8; k++)
      apply(mk(0, 1, 24'h60, 0, 1, 0, 24'(24'h300 + k), 24'h0, (k % 4) == 3, (k % 4) != 3));
    chk("conflict_after_8", 32'(conflict_cnt), 32'd8);
    apply(mk(0, 0, 24'h0, 0, 0, 0, 24'h0, 24'h0, 0, 0));

    // Saturation of the narrow conflict counter.
    apply(mk(1, 0, 24'h0, 0, 0, 0, 24'h0, 24'h0, 0, 0));
    for (int k = 0; k < 20; k++)
      apply(mk(0, 1, 24'h70, 0, 1, 0, 24'h400, 24'h0, (k % 4) == 3, (k % 4) != 3));
    chk("conflict4_sat", 32'(conflict_cnt4), 32'hF);
    chk("conflict_after_20", 32'(conflict_cnt), 32'd20);
    apply(mk(0, 0, 24'h0, 0, 0, 0, 24'h0, 24'h0, 0, 0));
    apply(mk(0, 0, 24'h0, 0, 0, 0, 24'h0, 24'h0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
